// File: rtl/btb_update_queue_if.sv
// Commit-side resolution inputs and BTB C1 update outputs of btb_update_queue.
// master = resolution producer / BTB consumer side, slave = the queue.
interface btb_update_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     res_valid_i;
  logic                     res_ready_o;
  logic [31:0]              res_pc_i;
  logic [31:0]              res_target_i;
  logic                     res_taken_i;
  logic [1:0]               res_type_i;
  logic                     res_is_branch_i;
  logic                     pred_hit_i;
  logic                     pred_way_i;
  logic [1:0]               pred_cntr_i;
  logic [31:0]              pred_target_i;
  logic [1:0]               pred_type_i;
  logic                     btb_correct_busy_i;
  logic [31:0]              c1_btb_vpc_o;
  logic [31:0]              c1_btb_target_o;
  logic [1:0]               c1_cntr_pred_o;
  logic                     c1_bnch_tkn_o;
  logic [1:0]               c1_bnch_type_o;
  logic                     c1_bnch_present_o;
  logic                     c1_btb_mod_o;
  logic                     c1_btb_way_o;
  logic                     c1_btb_bm_o;
  logic [$clog2(DEPTH):0]   occupancy_o;

  modport master (
    output res_valid_i, res_pc_i, res_target_i, res_taken_i, res_type_i,
           res_is_branch_i, pred_hit_i, pred_way_i, pred_cntr_i,
           pred_target_i, pred_type_i, btb_correct_busy_i,
    input  res_ready_o, c1_btb_vpc_o, c1_btb_target_o, c1_cntr_pred_o,
           c1_bnch_tkn_o, c1_bnch_type_o, c1_bnch_present_o, c1_btb_mod_o,
           c1_btb_way_o, c1_btb_bm_o, occupancy_o
  );

  modport slave (
    input  res_valid_i, res_pc_i, res_target_i, res_taken_i, res_type_i,
           res_is_branch_i, pred_hit_i, pred_way_i, pred_cntr_i,
           pred_target_i, pred_type_i, btb_correct_busy_i,
    output res_ready_o, c1_btb_vpc_o, c1_btb_target_o, c1_cntr_pred_o,
           c1_bnch_tkn_o, c1_bnch_type_o, c1_bnch_present_o, c1_btb_mod_o,
           c1_btb_way_o, c1_btb_bm_o, occupancy_o
  );
endinterface

// File: rtl/btb_update_queue.sv
// Filters resolved branches against their fetch-time prediction and queues the
// ones needing a BTB write (MOD) or bimodal counter update (BM) for the C1 port.
module btb_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic               cpu_clk_i,
  input logic               reset_ni,
  btb_update_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    KIND_BM  = 1'b0,
    KIND_MOD = 1'b1
  } kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  typ;
    logic        is_branch;
    logic        way;
    logic [1:0]  cntr;
    kind_e       kind;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_e;
  entry_t          new_e;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            ready;
  logic            empty;
  logic            is_mod;
  logic            is_bm;
  logic            mismatch;
  logic            saturated;
  logic            push;
  logic            pop;
  logic            issue_mod;
  logic            issue_bm;
  logic            unused_ptgt_lo;

  // Target low bits are below instruction granularity and never compared.
  assign unused_ptgt_lo = ^bus.pred_target_i[1:0];

  always_comb begin
    mismatch  = (bus.pred_type_i != bus.res_type_i) ||
                (bus.res_taken_i && (bus.pred_target_i[31:2] != bus.res_target_i[31:2]));
    saturated = bus.res_taken_i ? (bus.pred_cntr_i == 2'b11) : (bus.pred_cntr_i == 2'b00);
    is_mod    = (bus.pred_hit_i && !bus.res_is_branch_i) ||
                (bus.pred_hit_i && bus.res_is_branch_i && mismatch) ||
                (!bus.pred_hit_i && bus.res_is_branch_i && bus.res_taken_i);
    is_bm     = bus.pred_hit_i && bus.res_is_branch_i && (bus.res_type_i == 2'b00) &&
                !is_mod && !saturated;
  end

  always_comb begin
    new_e.pc        = bus.res_pc_i;
    new_e.target    = bus.res_target_i;
    new_e.taken     = bus.res_taken_i;
    new_e.typ       = bus.res_type_i;
    new_e.is_branch = bus.res_is_branch_i;
    new_e.way       = bus.pred_way_i;
    new_e.cntr      = bus.pred_cntr_i;
    new_e.kind      = is_mod ? KIND_MOD : KIND_BM;
  end

  assign ready  = (count != CW'(DEPTH));
  assign empty  = (count == '0);
  assign head_e = mem[head];

  // DROP resolutions complete the handshake but never occupy a slot.
  assign push = bus.res_valid_i && ready && (is_mod || is_bm);

  always_comb begin
    issue_mod = !empty && (head_e.kind == KIND_MOD);
    issue_bm  = !empty && (head_e.kind == KIND_BM) && !bus.btb_correct_busy_i;
    pop       = issue_mod || issue_bm;
  end

  always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= new_e;
        tail      <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.res_ready_o       = ready;
  assign bus.occupancy_o       = count;
  assign bus.c1_btb_vpc_o      = head_e.pc;
  assign bus.c1_btb_target_o   = head_e.target;
  assign bus.c1_cntr_pred_o    = head_e.cntr;
  assign bus.c1_bnch_tkn_o     = head_e.taken;
  assign bus.c1_bnch_type_o    = head_e.typ;
  assign bus.c1_bnch_present_o = head_e.is_branch;
  assign bus.c1_btb_way_o      = head_e.way;
  assign bus.c1_btb_mod_o      = issue_mod;
  assign bus.c1_btb_bm_o       = issue_bm;
endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: directed vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_btb_update_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btb_update_queue_if #(.DEPTH(DEPTH)) bus ();

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .cpu_clk_i (clk),
    .reset_ni  (rst_n),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  typ;
    logic        isb;
    logic        hit;
    logic        way;
    logic [1:0]  cntr;
    logic [31:0] ptarget;
    logic [1:0]  ptype;
  } res_t;

  typedef struct {
    res_t in;
    logic e_mod;
    logic e_bm;
  } vec_t;

  typedef struct {
    res_t r;
    logic is_mod;
  } ment_t;

  int total = 0;
  int bad   = 0;

  res_t  cur_res;
  logic  cur_valid;
  logic  cur_busy;
  ment_t mq[$];
  vec_t  v[13];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [31:0] pc, input logic [31:0] target,
                              input logic taken, input logic [1:0] typ, input logic isb,
                              input logic hit, input logic way, input logic [1:0] cntr,
                              input logic [31:0] ptarget, input logic [1:0] ptype);
    res_t r;
    r.pc = pc; r.target = target; r.taken = taken; r.typ = typ; r.isb = isb;
    r.hit = hit; r.way = way; r.cntr = cntr; r.ptarget = ptarget; r.ptype = ptype;
    return r;
  endfunction

  // 0 = no BTB change, 1 = entry rewrite/allocate/invalidate, 2 = counter update
  function automatic int classify(input res_t r);
    logic [1:0] sat_val;
    if (r.hit && !r.isb) return 1;
    if (!r.hit) return (r.isb && r.taken) ? 1 : 0;
    if (!r.isb) return 0;
    if (r.ptype != r.typ) return 1;
    if (r.taken && (r.ptarget >> 2) != (r.target >> 2)) return 1;
    if (r.typ != 2'b00) return 0;
    sat_val = r.taken ? 2'b11 : 2'b00;
    return (r.cntr == sat_val) ? 0 : 2;
  endfunction

  function automatic res_t rand_res();
    res_t r;
    r.pc      = 32'($urandom_range(0, 4095)) << 2;
    r.target  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    r.taken   = 1'($urandom_range(0, 1));
    r.typ     = 2'($urandom_range(0, 3));
    r.isb     = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
    r.hit     = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
    r.way     = 1'($urandom_range(0, 1));
    r.cntr    = 2'($urandom_range(0, 3));
    r.ptarget = ($urandom_range(0, 1) == 1) ? (r.target ^ 32'($urandom_range(0, 3)))
                                            : (32'($urandom_range(0, 15)) << 2);
    r.ptype   = ($urandom_range(0, 3) != 0) ? r.typ : 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic drive(input res_t r);
    cur_res   = r;
    cur_valid = 1'b1;
    bus.res_valid_i     = 1'b1;
    bus.res_pc_i        = r.pc;
    bus.res_target_i    = r.target;
    bus.res_taken_i     = r.taken;
    bus.res_type_i      = r.typ;
    bus.res_is_branch_i = r.isb;
    bus.pred_hit_i      = r.hit;
    bus.pred_way_i      = r.way;
    bus.pred_cntr_i     = r.cntr;
    bus.pred_target_i   = r.ptarget;
    bus.pred_type_i     = r.ptype;
  endtask

  task automatic idle();
    cur_valid       = 1'b0;
    bus.res_valid_i = 1'b0;
  endtask

  task automatic set_busy(input logic b);
    cur_busy               = b;
    bus.btb_correct_busy_i = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_data(input string tag, input res_t r);
    cmp({tag, "_vpc"},     bus.c1_btb_vpc_o,              r.pc);
    cmp({tag, "_target"},  bus.c1_btb_target_o,           r.target);
    cmp({tag, "_cntr"},    32'(bus.c1_cntr_pred_o),       32'(r.cntr));
    cmp({tag, "_tkn"},     32'(bus.c1_bnch_tkn_o),        32'(r.taken));
    cmp({tag, "_type"},    32'(bus.c1_bnch_type_o),       32'(r.typ));
    cmp({tag, "_present"}, 32'(bus.c1_bnch_present_o),    32'(r.isb));
    cmp({tag, "_way"},     32'(bus.c1_btb_way_o),         32'(r.way));
  endtask

  // Compare this cycle's outputs with the model, then advance it past the edge.
  task automatic model_step();
    logic exp_ready;
    int   cls;
    exp_ready = (mq.size() != int'(DEPTH));
    cmp("m_ready", 32'(bus.res_ready_o), 32'(exp_ready));
    cmp("m_occ",   32'(bus.occupancy_o), 32'(mq.size()));
    if (mq.size() == 0) begin
      cmp("m_mod_empty", 32'(bus.c1_btb_mod_o), 32'd0);
      cmp("m_bm_empty",  32'(bus.c1_btb_bm_o),  32'd0);
    end else begin
      cmp("m_mod", 32'(bus.c1_btb_mod_o), 32'(mq[0].is_mod));
      cmp("m_bm",  32'(bus.c1_btb_bm_o),  32'(!mq[0].is_mod && !cur_busy));
      check_data("m", mq[0].r);
    end
    cls = classify(cur_res);
    if (mq.size() > 0 && (mq[0].is_mod || !cur_busy)) void'(mq.pop_front());
    if (cur_valid && exp_ready && cls != 0) mq.push_back('{r: cur_res, is_mod: (cls == 1)});
  endtask

  initial begin
    v[0]  = '{in: mk(32'h1008, 32'h2000, 1, 2'b10, 1, 0, 0, 2'b00, 32'h0,   2'b00), e_mod: 1, e_bm: 0};
    v[1]  = '{in: mk(32'h0100, 32'h0400, 1, 2'b00, 1, 1, 0, 2'b10, 32'h400, 2'b00), e_mod: 0, e_bm: 1};
    v[2]  = '{in: mk(32'h0100, 32'h0400, 1, 2'b00, 1, 1, 0, 2'b11, 32'h400, 2'b00), e_mod: 0, e_bm: 0};
    v[3]  = '{in: mk(32'h0300, 32'h0000, 0, 2'b00, 0, 1, 1, 2'b01, 32'h0,   2'b00), e_mod: 1, e_bm: 0};
    v[4]  = '{in: mk(32'h0140, 32'h0480, 0, 2'b00, 1, 1, 0, 2'b00, 32'h480, 2'b00), e_mod: 0, e_bm: 0};
    v[5]  = '{in: mk(32'h0144, 32'h0480, 0, 2'b00, 1, 1, 1, 2'b01, 32'h480, 2'b00), e_mod: 0, e_bm: 1};
    v[6]  = '{in: mk(32'h0200, 32'h0800, 1, 2'b01, 1, 1, 1, 2'b11, 32'h800, 2'b00), e_mod: 1, e_bm: 0};
    v[7]  = '{in: mk(32'h0240, 32'h0506, 1, 2'b10, 1, 1, 0, 2'b00, 32'h504, 2'b10), e_mod: 0, e_bm: 0};
    v[8]  = '{in: mk(32'h0244, 32'h0504, 1, 2'b10, 1, 1, 0, 2'b00, 32'h500, 2'b10), e_mod: 1, e_bm: 0};
    v[9]  = '{in: mk(32'h0180, 32'h0900, 0, 2'b00, 1, 1, 1, 2'b10, 32'h904, 2'b00), e_mod: 0, e_bm: 1};
    v[10] = '{in: mk(32'h01c0, 32'h0300, 0, 2'b00, 1, 0, 0, 2'b00, 32'h0,   2'b00), e_mod: 0, e_bm: 0};
    v[11] = '{in: mk(32'h01c4, 32'h0000, 1, 2'b00, 0, 0, 0, 2'b00, 32'h0,   2'b00), e_mod: 0, e_bm: 0};
    v[12] = '{in: mk(32'h02c0, 32'h07f0, 1, 2'b11, 1, 1, 0, 2'b11, 32'h7f0, 2'b11), e_mod: 0, e_bm: 0};

    rst_n = 1'b0;
    drive(v[0].in);
    idle();
    set_busy(1'b0);
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_occ",   32'(bus.occupancy_o), 32'd0);
    cmp("rst_ready", 32'(bus.res_ready_o), 32'd1);
    cmp("rst_mod",   32'(bus.c1_btb_mod_o), 32'd0);
    cmp("rst_bm",    32'(bus.c1_btb_bm_o),  32'd0);
    check_data("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();

    // Directed vectors, one resolution at a time from an empty queue.
    for (int i = 0; i < 13; i++) begin
      drive(v[i].in);
      tick();
      idle();
      @(negedge clk);
      cmp($sformatf("v%0d_occ", i), 32'(bus.occupancy_o), 32'(v[i].e_mod || v[i].e_bm));
      cmp($sformatf("v%0d_mod", i), 32'(bus.c1_btb_mod_o), 32'(v[i].e_mod));
      cmp($sformatf("v%0d_bm", i),  32'(bus.c1_btb_bm_o),  32'(v[i].e_bm));
      if (v[i].e_mod || v[i].e_bm) check_data($sformatf("v%0d", i), v[i].in);
      tick();
      @(negedge clk);
      cmp($sformatf("v%0d_drain", i), 32'(bus.occupancy_o), 32'd0);
      tick();
    end

    // BM stalled behind a decode correction for three cycles.
    set_busy(1'b1);
    drive(v[1].in);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp($sformatf("stall%0d_bm", i),  32'(bus.c1_btb_bm_o),  32'd0);
      cmp($sformatf("stall%0d_mod", i), 32'(bus.c1_btb_mod_o), 32'd0);
      cmp($sformatf("stall%0d_occ", i), 32'(bus.occupancy_o),  32'd1);
      cmp($sformatf("stall%0d_vpc", i), bus.c1_btb_vpc_o,      32'h0100);
      tick();
    end
    set_busy(1'b0);
    @(negedge clk);
    cmp("stall_release_bm", 32'(bus.c1_btb_bm_o), 32'd1);
    tick();
    @(negedge clk);
    cmp("stall_release_occ", 32'(bus.occupancy_o), 32'd0);
    tick();

    // Asynchronous reset with three entries held behind a stalled BM.
    set_busy(1'b1);
    drive(v[1].in); tick();
    drive(v[0].in); tick();
    drive(v[3].in); tick();
    idle();
    @(negedge clk);
    cmp("pre_rst_occ", 32'(bus.occupancy_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_occ",   32'(bus.occupancy_o), 32'd0);
    cmp("arst_mod",   32'(bus.c1_btb_mod_o), 32'd0);
    cmp("arst_bm",    32'(bus.c1_btb_bm_o),  32'd0);
    cmp("arst_ready", 32'(bus.res_ready_o), 32'd1);
    cmp("arst_vpc",   bus.c1_btb_vpc_o,     32'h0);
    tick();
    rst_n = 1'b1;
    set_busy(1'b0);
    tick();

    // Fill to DEPTH behind a stalled BM, then stream MODs across pointer wrap.
    mq.delete();
    set_busy(1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(v[1].in);
      else drive(mk(32'h1000 + 32'(4 * k), 32'h2000, 1, 2'b10, 1, 0, 0, 2'b00, 32'h0, 2'b00));
      @(negedge clk);
      model_step();
      tick();
    end
    idle();
    @(negedge clk);
    cmp("full_ready", 32'(bus.res_ready_o), 32'd0);
    cmp("full_occ",   32'(bus.occupancy_o), 32'd4);
    model_step();
    tick();
    set_busy(1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(mk(32'h3000 + 32'(4 * k), 32'h2400, 1, 2'b10, 1, 0, k[0], 2'b00, 32'h0, 2'b00));
      @(negedge clk);
      model_step();
      tick();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      model_step();
      tick();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      drive(rand_res());
      if ($urandom_range(0, 99) < 30) idle();
      set_busy(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
      @(negedge clk);
      model_step();
      tick();
    end
    idle();
    set_busy(1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      model_step();
      tick();
    end
    cmp("final_occ", 32'(bus.occupancy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
